// File: rtl/serdes_word_assembler_if.sv
// Byte stream in from the SERDES, slot words and link status out.
// The slave modport is the assembler's view; the master modport is the SERDES/consumer side.
interface serdes_word_assembler_if;
    logic [7:0]  RXDATA;
    logic        RXVALID;
    logic        BITSLIP;
    logic [63:0] DATA;
    logic        DVALID;
    logic        LOCKED;
    logic [15:0] FRAMECNT;
    logic [7:0]  ERRCNT;

    modport slave (
        input  RXDATA,
        input  RXVALID,
        output BITSLIP,
        output DATA,
        output DVALID,
        output LOCKED,
        output FRAMECNT,
        output ERRCNT
    );

    modport master (
        output RXDATA,
        output RXVALID,
        input  BITSLIP,
        input  DATA,
        input  DVALID,
        input  LOCKED,
        input  FRAMECNT,
        input  ERRCNT
    );
endinterface

// File: rtl/serdes_word_assembler.sv
// Aligns to a stream of idle characters, slips bits while hunting, and packs
// SOF-delimited eight-byte payloads into 64-bit words.
module serdes_word_assembler #(
    parameter logic [7:0] IDLE_CHAR    = 8'hBC,
    parameter logic [7:0] SOF_CHAR     = 8'hFB,
    parameter int unsigned LOCK_CNT     = 4,
    parameter int unsigned SLIP_TIMEOUT = 16,
    parameter int unsigned ERR_MAX      = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    serdes_word_assembler_if.slave  bus
);

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        SLIP    = 3'd1,
        ALIGN   = 3'd2,
        IDLE    = 3'd3,
        PAYLOAD = 3'd4
    } state_t;

    localparam logic [3:0] LOCK_W = LOCK_CNT[3:0];
    localparam logic [7:0] SLIP_W = SLIP_TIMEOUT[7:0];
    localparam logic [3:0] ERR_W  = ERR_MAX[3:0];

    state_t      state_r;
    logic [7:0]  hunt_cnt_r;
    logic [3:0]  idle_cnt_r;
    logic [3:0]  err_cnt_r;
    logic [2:0]  idx_r;
    logic [1:0]  slip_cnt_r;
    logic [63:0] shadow_r;
    logic [63:0] data_r;
    logic        dvalid_r;
    logic        bitslip_r;
    logic        locked_r;
    logic [15:0] framecnt_r;
    logic [7:0]  errcnt_r;

    logic [7:0]  rxdata_s;
    logic        rxvalid_s;

    assign rxdata_s     = bus.RXDATA;
    assign rxvalid_s    = bus.RXVALID;
    assign bus.BITSLIP  = bitslip_r;
    assign bus.DATA     = data_r;
    assign bus.DVALID   = dvalid_r;
    assign bus.LOCKED   = locked_r;
    assign bus.FRAMECNT = framecnt_r;
    assign bus.ERRCNT   = errcnt_r;

    // Link FSM together with all counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= HUNT;
            hunt_cnt_r <= 8'd0;
            idle_cnt_r <= 4'd0;
            err_cnt_r  <= 4'd0;
            idx_r      <= 3'd0;
            slip_cnt_r <= 2'd0;
            shadow_r   <= 64'd0;
            data_r     <= 64'd0;
            dvalid_r   <= 1'b0;
            bitslip_r  <= 1'b0;
            locked_r   <= 1'b0;
            framecnt_r <= 16'd0;
            errcnt_r   <= 8'd0;
        end else begin
            dvalid_r  <= 1'b0;
            bitslip_r <= 1'b0;
            case (state_r)
                HUNT: begin
                    if (rxvalid_s) begin
                        if (rxdata_s == IDLE_CHAR) begin
                            hunt_cnt_r <= 8'd0;
                            if (LOCK_W == 4'd1) begin
                                state_r    <= IDLE;
                                locked_r   <= 1'b1;
                                idle_cnt_r <= 4'd0;
                                err_cnt_r  <= 4'd0;
                            end else begin
                                state_r    <= ALIGN;
                                idle_cnt_r <= 4'd1;
                            end
                        end else if (hunt_cnt_r + 8'd1 == SLIP_W) begin
                            hunt_cnt_r <= 8'd0;
                            bitslip_r  <= 1'b1;
                            slip_cnt_r <= 2'd0;
                            state_r    <= SLIP;
                        end else begin
                            hunt_cnt_r <= hunt_cnt_r + 8'd1;
                        end
                    end
                end
                // The SERDES needs a few cycles to settle after a slip, so input is ignored here.
                SLIP: begin
                    if (slip_cnt_r == 2'd3) begin
                        slip_cnt_r <= 2'd0;
                        state_r    <= HUNT;
                    end else begin
                        slip_cnt_r <= slip_cnt_r + 2'd1;
                    end
                end
                ALIGN: begin
                    if (rxvalid_s) begin
                        if (rxdata_s == IDLE_CHAR) begin
                            if (idle_cnt_r + 4'd1 == LOCK_W) begin
                                state_r    <= IDLE;
                                locked_r   <= 1'b1;
                                idle_cnt_r <= 4'd0;
                                err_cnt_r  <= 4'd0;
                            end else begin
                                idle_cnt_r <= idle_cnt_r + 4'd1;
                            end
                        end else begin
                            state_r    <= HUNT;
                            idle_cnt_r <= 4'd0;
                            hunt_cnt_r <= 8'd0;
                        end
                    end
                end
                IDLE: begin
                    if (rxvalid_s) begin
                        if (rxdata_s == IDLE_CHAR) begin
                            err_cnt_r <= 4'd0;
                        end else if (rxdata_s == SOF_CHAR) begin
                            state_r   <= PAYLOAD;
                            idx_r     <= 3'd0;
                            err_cnt_r <= 4'd0;
                        end else begin
                            if (errcnt_r != 8'hFF) begin
                                errcnt_r <= errcnt_r + 8'd1;
                            end
                            if (err_cnt_r + 4'd1 == ERR_W) begin
                                state_r    <= HUNT;
                                locked_r   <= 1'b0;
                                err_cnt_r  <= 4'd0;
                                hunt_cnt_r <= 8'd0;
                                idle_cnt_r <= 4'd0;
                            end else begin
                                err_cnt_r <= err_cnt_r + 4'd1;
                            end
                        end
                    end
                end
                // Bytes land in a shadow word so DATA only ever shows complete frames.
                PAYLOAD: begin
                    if (rxvalid_s) begin
                        shadow_r[{idx_r, 3'b000} +: 8] <= rxdata_s;
                        if (idx_r == 3'd7) begin
                            data_r     <= {rxdata_s, shadow_r[55:0]};
                            dvalid_r   <= 1'b1;
                            framecnt_r <= framecnt_r + 16'd1;
                            idx_r      <= 3'd0;
                            state_r    <= IDLE;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end
                end
                default: begin
                    state_r  <= HUNT;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serdes_word_assembler.sv
// Directed bench for serdes_word_assembler: lock, framing, bitslip, errors,
// stalls with back-to-back frames and reset in the middle of a frame.
module tb_serdes_word_assembler;

    logic CLK;
    logic RST;
    int   errors;
    int   checks;

    serdes_word_assembler_if bus();

    serdes_word_assembler dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Present one byte, let the next rising edge sample it, then settle 1 time unit.
    task automatic drive(input logic [7:0] d, input logic v);
        bus.RXDATA  = d;
        bus.RXVALID = v;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST         = 1'b1;
        bus.RXDATA  = 8'hBC;
        bus.RXVALID = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic lock_link();
        for (int i = 0; i < 4; i++) drive(8'hBC, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.LOCKED !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", bus.LOCKED); end
        checks++; if (bus.DVALID !== 1'b0) begin errors++; $display("FAIL reset_dvalid: got %b expected 0", bus.DVALID); end
        checks++; if (bus.BITSLIP !== 1'b0) begin errors++; $display("FAIL reset_bitslip: got %b expected 0", bus.BITSLIP); end
        checks++; if (bus.DATA !== 64'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.DATA); end
        checks++; if (bus.FRAMECNT !== 16'd0) begin errors++; $display("FAIL reset_framecnt: got %0d expected 0", bus.FRAMECNT); end
        checks++; if (bus.ERRCNT !== 8'd0) begin errors++; $display("FAIL reset_errcnt: got %0d expected 0", bus.ERRCNT); end
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(8'hBC, 1'b1);
            checks++; if (bus.LOCKED !== 1'b0) begin errors++; $display("FAIL lock_partial[%0d]: got %b expected 0", i, bus.LOCKED); end
        end
        drive(8'h00, 1'b1);
        checks++; if (bus.LOCKED !== 1'b0) begin errors++; $display("FAIL lock_broken: got %b expected 0", bus.LOCKED); end
        for (int i = 0; i < 4; i++) begin
            drive(8'hBC, 1'b1);
            checks++; if (bus.LOCKED !== (i == 3)) begin errors++; $display("FAIL lock_seq[%0d]: got %b expected %b", i, bus.LOCKED, (i == 3)); end
        end
    endtask

    task automatic test_frame();
        logic [7:0] b;
        drive(8'hFB, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            drive(b, 1'b1);
            if (i < 8) begin
                checks++; if (bus.DVALID !== 1'b0 || bus.DATA !== 64'd0) begin errors++; $display("FAIL frame_partial[%0d]: got dvalid=%b data=%h expected 0/0", i, bus.DVALID, bus.DATA); end
            end
        end
        checks++; if (bus.DVALID !== 1'b1) begin errors++; $display("FAIL frame_dvalid: got %b expected 1", bus.DVALID); end
        checks++; if (bus.DATA !== 64'h0807060504030201) begin errors++; $display("FAIL frame_data: got %h expected 0807060504030201", bus.DATA); end
        checks++; if (bus.FRAMECNT !== 16'd1) begin errors++; $display("FAIL frame_cnt: got %0d expected 1", bus.FRAMECNT); end
        drive(8'hBC, 1'b1);
        checks++; if (bus.DVALID !== 1'b0) begin errors++; $display("FAIL frame_pulse: got %b expected 0", bus.DVALID); end
        checks++; if (bus.DATA !== 64'h0807060504030201) begin errors++; $display("FAIL frame_hold: got %h expected 0807060504030201", bus.DATA); end
        checks++; if (bus.LOCKED !== 1'b1) begin errors++; $display("FAIL frame_locked: got %b expected 1", bus.LOCKED); end
    endtask

    task automatic test_errors();
        logic [7:0] seq [5];
        seq = '{8'h11, 8'hBC, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 5; i++) begin
            drive(seq[i], 1'b1);
            checks++; if (bus.LOCKED !== (i != 4)) begin errors++; $display("FAIL err_locked[%0d]: got %b expected %b", i, bus.LOCKED, (i != 4)); end
        end
        checks++; if (bus.ERRCNT !== 8'd4) begin errors++; $display("FAIL err_count: got %0d expected 4", bus.ERRCNT); end
        checks++; if (bus.FRAMECNT !== 16'd1) begin errors++; $display("FAIL err_framecnt: got %0d expected 1", bus.FRAMECNT); end
    endtask

    task automatic test_bitslip();
        int pulses;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            drive(8'h55, 1'b1);
            if (bus.BITSLIP === 1'b1) pulses++;
            checks++; if (bus.BITSLIP !== (i == 15 || i == 35)) begin errors++; $display("FAIL slip_pulse[%0d]: got %b expected %b", i, bus.BITSLIP, (i == 15 || i == 35)); end
        end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL slip_total: got %0d expected 2", pulses); end
        // Idle bytes during the four SLIP cycles must not count toward lock.
        do_reset();
        for (int i = 0; i < 16; i++) drive(8'h55, 1'b1);
        for (int i = 0; i < 4; i++) drive(8'hBC, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(8'hBC, 1'b1);
            checks++; if (bus.LOCKED !== (i == 3)) begin errors++; $display("FAIL slip_ignore[%0d]: got %b expected %b", i, bus.LOCKED, (i == 3)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        do_reset();
        lock_link();
        drive(8'hFB, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(8'h33, 1'b0);
            checks++; if (bus.DVALID !== 1'b0) begin errors++; $display("FAIL stall_gap[%0d]: got %b expected 0", i, bus.DVALID); end
            b = 8'h11 + 8'(i);
            drive(b, 1'b1);
            checks++; if (bus.DVALID !== (i == 7)) begin errors++; $display("FAIL stall_byte[%0d]: got %b expected %b", i, bus.DVALID, (i == 7)); end
        end
        checks++; if (bus.DATA !== 64'h1817161514131211) begin errors++; $display("FAIL stall_data: got %h expected 1817161514131211", bus.DATA); end
        drive(8'hFB, 1'b1);
        checks++; if (bus.DVALID !== 1'b0) begin errors++; $display("FAIL b2b_sof: got %b expected 0", bus.DVALID); end
        for (int i = 0; i < 8; i++) begin
            drive(8'hAA, 1'b1);
            checks++; if (bus.DVALID !== (i == 7)) begin errors++; $display("FAIL b2b_byte[%0d]: got %b expected %b", i, bus.DVALID, (i == 7)); end
        end
        checks++; if (bus.DATA !== 64'hAAAA_AAAA_AAAA_AAAA) begin errors++; $display("FAIL b2b_data: got %h expected aaaaaaaaaaaaaaaa", bus.DATA); end
        checks++; if (bus.FRAMECNT !== 16'd2) begin errors++; $display("FAIL b2b_framecnt: got %0d expected 2", bus.FRAMECNT); end
        checks++; if (bus.ERRCNT !== 8'd0) begin errors++; $display("FAIL b2b_errcnt: got %0d expected 0", bus.ERRCNT); end
        checks++; if (bus.LOCKED !== 1'b1) begin errors++; $display("FAIL b2b_locked: got %b expected 1", bus.LOCKED); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        do_reset();
        lock_link();
        drive(8'h11, 1'b1);
        drive(8'hFB, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            drive(b, 1'b1);
        end
        checks++; if (bus.ERRCNT !== 8'd1 || bus.FRAMECNT !== 16'd1) begin errors++; $display("FAIL mid_pre: got errcnt=%0d framecnt=%0d expected 1/1", bus.ERRCNT, bus.FRAMECNT); end
        drive(8'hFB, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            b = 8'(i);
            drive(b, 1'b1);
        end
        do_reset();
        checks++; if (bus.DATA !== 64'd0 || bus.DVALID !== 1'b0 || bus.BITSLIP !== 1'b0) begin errors++; $display("FAIL mid_rst_data: got data=%h dvalid=%b bitslip=%b expected 0", bus.DATA, bus.DVALID, bus.BITSLIP); end
        checks++; if (bus.LOCKED !== 1'b0 || bus.FRAMECNT !== 16'd0 || bus.ERRCNT !== 8'd0) begin errors++; $display("FAIL mid_rst_cnt: got locked=%b framecnt=%0d errcnt=%0d expected 0", bus.LOCKED, bus.FRAMECNT, bus.ERRCNT); end
        for (int i = 5; i <= 8; i++) begin
            b = 8'(i);
            drive(b, 1'b1);
            checks++; if (bus.DVALID !== 1'b0 || bus.LOCKED !== 1'b0) begin errors++; $display("FAIL mid_tail[%0d]: got dvalid=%b locked=%b expected 0/0", i, bus.DVALID, bus.LOCKED); end
        end
        drive(8'hFB, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            drive(b, 1'b1);
            checks++; if (bus.DVALID !== 1'b0) begin errors++; $display("FAIL mid_unlocked[%0d]: got %b expected 0", i, bus.DVALID); end
        end
        lock_link();
        drive(8'hFB, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            b = 8'h20 + 8'(i);
            drive(b, 1'b1);
        end
        checks++; if (bus.DVALID !== 1'b1) begin errors++; $display("FAIL mid_relock_dvalid: got %b expected 1", bus.DVALID); end
        checks++; if (bus.DATA !== 64'h2827262524232221) begin errors++; $display("FAIL mid_relock_data: got %h expected 2827262524232221", bus.DATA); end
        checks++; if (bus.FRAMECNT !== 16'd1) begin errors++; $display("FAIL mid_relock_cnt: got %0d expected 1", bus.FRAMECNT); end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        RST         = 1'b0;
        bus.RXDATA  = 8'h00;
        bus.RXVALID = 1'b0;
        test_reset();
        test_lock();
        test_frame();
        test_errors();
        test_bitslip();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
